// File: rtl/etapa_pipe_reg.sv
// Pipeline-stage register for the MIPS datapath: 1..4 stages of {valid, data, ctrl}; counters under PIPE_STATS_EN.
// Latency: STAGES enabled, non-stalled cycles from i_Data to o_Data; outputs come straight from the last stage.
// Backpressure: i_Stall holds every stage, i_Flush (wins over stall) bubbles every stage, i_Enable=0 freezes all state.
module etapa_pipe_reg #(
    parameter int                DBITS      = 32,
    parameter int                CBITS      = 16,
    parameter logic [CBITS-1:0]  CTRL_RST   = {CBITS{1'b0}},
    parameter int                STAGES     = 1,
    parameter int                CLEAR_DATA = 0,
    parameter int                CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_Enable,
    input  logic             i_Stall,
    input  logic             i_Flush,
    input  logic             i_Valid,
    input  logic [DBITS-1:0] i_Data,
    input  logic [CBITS-1:0] i_Ctrl,
    input  logic             i_CntClear,
    output logic             o_Valid,
    output logic [DBITS-1:0] o_Data,
    output logic [CBITS-1:0] o_Ctrl,
    output logic [CNT_W-1:0] o_StallCnt,
    output logic [CNT_W-1:0] o_FlushCnt
);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $fatal(1, "etapa_pipe_reg: STAGES must be in 1..4");
    end

    localparam int LAST = STAGES - 1;

    logic             r_valid [STAGES];
    logic [DBITS-1:0] r_data  [STAGES];
    logic [CBITS-1:0] r_ctrl  [STAGES];

    // A stage loaded with valid=0 always carries CTRL_RST, so bubbles never write anything.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
                r_ctrl[k]  <= CTRL_RST;
            end
        end else if (i_Enable) begin
            if (i_Flush) begin
                for (int k = 0; k < STAGES; k++) begin
                    r_valid[k] <= 1'b0;
                    r_ctrl[k]  <= CTRL_RST;
                    if (CLEAR_DATA != 0) begin
                        r_data[k] <= '0;
                    end
                end
            end else if (!i_Stall) begin
                r_valid[0] <= i_Valid;
                r_data[0]  <= i_Data;
                r_ctrl[0]  <= i_Valid ? i_Ctrl : CTRL_RST;
                for (int k = 1; k < STAGES; k++) begin
                    r_valid[k] <= r_valid[k-1];
                    r_data[k]  <= r_data[k-1];
                    r_ctrl[k]  <= r_valid[k-1] ? r_ctrl[k-1] : CTRL_RST;
                end
            end
        end
    end

    assign o_Valid = r_valid[LAST];
    assign o_Data  = r_data[LAST];
    assign o_Ctrl  = r_valid[LAST] ? r_ctrl[LAST] : CTRL_RST;

`ifdef PIPE_STATS_EN
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Counters freeze with the rest of the block; clear beats an increment in the same cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (i_Enable) begin
            if (i_CntClear) begin
                r_stall_cnt <= '0;
                r_flush_cnt <= '0;
            end else begin
                if (i_Flush && !(&r_flush_cnt)) begin
                    r_flush_cnt <= r_flush_cnt + C_ONE;
                end
                if (i_Stall && !i_Flush && !(&r_stall_cnt)) begin
                    r_stall_cnt <= r_stall_cnt + C_ONE;
                end
            end
        end
    end

    assign o_StallCnt = r_stall_cnt;
    assign o_FlushCnt = r_flush_cnt;
`else
    logic w_unused_cntclear;
    assign w_unused_cntclear = i_CntClear;
    assign o_StallCnt        = '0;
    assign o_FlushCnt        = '0;
`endif

endmodule

// File: tb/tb_etapa_pipe_reg.sv
// Directed bench for etapa_pipe_reg: three instances (2-stage clear-data, 1-stage 4-bit counters, 4-stage)
// share one stimulus stream; every expected value below is hand-derived.
module tb_etapa_pipe_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, stall, flush, vld, cntclr;
    logic [7:0]  dat;
    logic [15:0] ctl;

    logic        a_vld, b_vld, c_vld;
    logic [7:0]  a_dat, b_dat, c_dat;
    logic [15:0] a_ctl, b_ctl, c_ctl;
    logic [15:0] a_scnt, a_fcnt, c_scnt, c_fcnt;
    logic [3:0]  b_scnt, b_fcnt;

    etapa_pipe_reg #(.DBITS(8), .CBITS(16), .CTRL_RST(16'h0003), .STAGES(2), .CLEAR_DATA(1), .CNT_W(16)) u_a (
        .i_clk(clk), .i_reset(rst), .i_Enable(en), .i_Stall(stall), .i_Flush(flush), .i_Valid(vld),
        .i_Data(dat), .i_Ctrl(ctl), .i_CntClear(cntclr), .o_Valid(a_vld), .o_Data(a_dat), .o_Ctrl(a_ctl),
        .o_StallCnt(a_scnt), .o_FlushCnt(a_fcnt));

    etapa_pipe_reg #(.DBITS(8), .CBITS(16), .CTRL_RST(16'h0000), .STAGES(1), .CLEAR_DATA(0), .CNT_W(4)) u_b (
        .i_clk(clk), .i_reset(rst), .i_Enable(en), .i_Stall(stall), .i_Flush(flush), .i_Valid(vld),
        .i_Data(dat), .i_Ctrl(ctl), .i_CntClear(cntclr), .o_Valid(b_vld), .o_Data(b_dat), .o_Ctrl(b_ctl),
        .o_StallCnt(b_scnt), .o_FlushCnt(b_fcnt));

    etapa_pipe_reg #(.DBITS(8), .CBITS(16), .CTRL_RST(16'h0000), .STAGES(4), .CLEAR_DATA(0), .CNT_W(16)) u_c (
        .i_clk(clk), .i_reset(rst), .i_Enable(en), .i_Stall(stall), .i_Flush(flush), .i_Valid(vld),
        .i_Data(dat), .i_Ctrl(ctl), .i_CntClear(cntclr), .o_Valid(c_vld), .o_Data(c_dat), .o_Ctrl(c_ctl),
        .o_StallCnt(c_scnt), .o_FlushCnt(c_fcnt));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Counters exist only when the statistics build is selected.
    function automatic logic [31:0] cexp(input int v);
`ifdef PIPE_STATS_EN
        return 32'(v);
`else
        return 32'(v * 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] d [6];

    initial begin
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        rst = 1'b1; en = 1'b1; stall = 1'b0; flush = 1'b0; vld = 1'b0; cntclr = 1'b0;
        dat = 8'h00; ctl = 16'h0000;
        #12;
        chk("rst_a_vld",  32'(a_vld), 32'h0);
        chk("rst_a_dat",  32'(a_dat), 32'h0);
        chk("rst_a_ctl",  32'(a_ctl), 32'h3);
        chk("rst_b_ctl",  32'(b_ctl), 32'h0);
        chk("rst_b_scnt", 32'(b_scnt), 32'h0);
        chk("rst_a_fcnt", 32'(a_fcnt), 32'h0);
        tick();
        rst = 1'b0;

        // Run a payload in, then hit reset asynchronously between edges.
        vld = 1'b1; dat = 8'h77; ctl = 16'h1234;
        tick();
        tick();
        chk("pre_a_dat", 32'(a_dat), 32'h77);
        #3 rst = 1'b1;
        #1;
        chk("arst_a_vld", 32'(a_vld), 32'h0);
        chk("arst_a_dat", 32'(a_dat), 32'h0);
        chk("arst_a_ctl", 32'(a_ctl), 32'h3);
        chk("arst_c_vld", 32'(c_vld), 32'h0);
        tick();
        rst = 1'b0;

        // Fill: 2-stage shows d[e-2], 1-stage d[e-1], 4-stage d[e-4] after edge e.
        for (int e = 1; e <= 6; e++) begin
            dat = d[e-1]; ctl = {8'hC0, d[e-1]}; vld = 1'b1;
            tick();
            chk("fill_b_dat", 32'(b_dat), 32'(d[e-1]));
            if (e >= 2) begin
                chk("fill_a_dat", 32'(a_dat), 32'(d[e-2]));
                chk("fill_a_ctl", 32'(a_ctl), 32'({8'hC0, d[e-2]}));
                chk("fill_a_vld", 32'(a_vld), 32'h1);
            end else begin
                chk("fill_a_vld0", 32'(a_vld), 32'h0);
                chk("fill_a_ctl0", 32'(a_ctl), 32'h3);
            end
            if (e >= 4) chk("fill_c_dat", 32'(c_dat), 32'(d[e-4]));
            else        chk("fill_c_vld0", 32'(c_vld), 32'h0);
        end

        // Stall hold.
        dat = 8'hA5; ctl = 16'h00A5;
        tick();
        chk("st_b_load", 32'(b_dat), 32'hA5);
        stall = 1'b1; dat = 8'h5A; ctl = 16'h005A;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_b_hold", 32'(b_dat), 32'hA5);
        end
        stall = 1'b0;
        tick();
        chk("st_b_rel",  32'(b_dat), 32'h5A);
        chk("st_a_rel",  32'(a_dat), 32'hA5);
        chk("st_c_rel",  32'(c_dat), 32'h55);
        chk("st_b_scnt", 32'(b_scnt), cexp(3));

        // Flush together with stall.
        dat = 8'hC3; ctl = 16'hFFFF; vld = 1'b1;
        tick();
        chk("fl_b_ctl_pre", 32'(b_ctl), 32'hFFFF);
        flush = 1'b1; stall = 1'b1; dat = 8'h99;
        tick();
        flush = 1'b0; stall = 1'b0;
        chk("fl_b_vld",  32'(b_vld), 32'h0);
        chk("fl_b_ctl",  32'(b_ctl), 32'h0);
        chk("fl_b_dat",  32'(b_dat), 32'hC3);
        chk("fl_a_dat",  32'(a_dat), 32'h0);
        chk("fl_a_ctl",  32'(a_ctl), 32'h3);
        chk("fl_c_dat",  32'(c_dat), 32'h66);
        chk("fl_c_vld",  32'(c_vld), 32'h0);
        chk("fl_b_fcnt", 32'(b_fcnt), cexp(1));
        chk("fl_b_scnt", 32'(b_scnt), cexp(3));
        chk("fl_a_scnt", 32'(a_scnt), cexp(3));

        // Bubble with live-looking control bits.
        vld = 1'b0; dat = 8'h44; ctl = 16'h00FF;
        tick();
        chk("bub_b_vld", 32'(b_vld), 32'h0);
        chk("bub_b_ctl", 32'(b_ctl), 32'h0);
        chk("bub_b_dat", 32'(b_dat), 32'h44);
        tick();
        chk("bub_a_ctl", 32'(a_ctl), 32'h3);
        chk("bub_a_dat", 32'(a_dat), 32'h44);

        // Debug freeze.
        vld = 1'b1; dat = 8'h3C; ctl = 16'h0F0F;
        tick();
        tick();
        chk("frz_a_pre", 32'(a_ctl), 32'h0F0F);
        for (int i = 0; i < 4; i++) begin
            en = 1'b0; flush = (i % 2 == 0); stall = (i % 2 == 1); dat = 8'hE0 + 8'(i);
            tick();
            chk("frz_b_dat",  32'(b_dat), 32'h3C);
            chk("frz_b_vld",  32'(b_vld), 32'h1);
            chk("frz_a_ctl",  32'(a_ctl), 32'h0F0F);
            chk("frz_b_scnt", 32'(b_scnt), cexp(3));
            chk("frz_b_fcnt", 32'(b_fcnt), cexp(1));
        end
        en = 1'b1; flush = 1'b0; stall = 1'b0; dat = 8'hD2; ctl = 16'h0D2D;
        tick();
        chk("frz_b_run", 32'(b_dat), 32'hD2);
        chk("frz_a_run", 32'(a_dat), 32'h3C);

        // Saturation of the 4-bit stall counter, then clear alongside a stall.
        stall = 1'b1;
        repeat (20) tick();
        chk("sat_b_scnt", 32'(b_scnt), cexp(15));
        chk("sat_a_scnt", 32'(a_scnt), cexp(23));
        chk("sat_b_dat",  32'(b_dat), 32'hD2);
        cntclr = 1'b1;
        tick();
        cntclr = 1'b0;
        chk("clr_b_scnt", 32'(b_scnt), 32'h0);
        chk("clr_b_fcnt", 32'(b_fcnt), 32'h0);
        chk("clr_a_scnt", 32'(a_scnt), 32'h0);

        // Asynchronous reset in the middle of a stall.
        #3 rst = 1'b1;
        #1;
        chk("arst2_b_vld", 32'(b_vld), 32'h0);
        chk("arst2_b_dat", 32'(b_dat), 32'h0);
        chk("arst2_c_dat", 32'(c_dat), 32'h0);
        rst = 1'b0;
        stall = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/etapa_pipe_reg.md
# etapa_pipe_reg

Parametrised pipeline-stage register for the MIPS datapath. It generalises the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block with the following features:
- configurable data and control widths;
- configurable depth of 1–4 stages;
- a per-stage valid bit;
- stall (hold), flush (bubble insertion) and debug-unit freeze;
- optional saturating stall/flush counters.

Every inter-stage boundary in the pipeline is instantiated from this block.

## Interface
Parameters:
- DBITS, 32, width of the data payload (PC, operands, immediates, register indices, packed by the instantiator).
- CBITS, 16, width of the control payload (EX/M/WB control bits); these are cleared on flush.
- CTRL_RST, {CBITS{1'b0}}, value loaded into the control payload on reset and on flush.
- STAGES, 1, number of register stages in series; legal range 1..4.
- CLEAR_DATA, 0, if 1, flush also zeroes the data payload; if 0, the data payload keeps its last value on flush.
- CNT_W, 16, width of each statistics counter.

Ports:
- i_clk, in, 1, clock; all state updates on the rising edge.
- i_reset, in, 1, reset; asynchronous and active-high.
- i_Enable, in, 1, debug-unit run/step enable; 0 freezes all state, including flush.
- i_Stall, in, 1, hazard-unit stall; holds all stages.
- i_Flush, in, 1, branch/jump flush; turns every stage into a bubble.
- i_Valid, in, 1, valid bit of the incoming instruction.
- i_Data, in, DBITS, incoming data payload.
- i_Ctrl, in, CBITS, incoming control payload.
- i_CntClear, in, 1, synchronous clear of both counters.
- o_Valid, out, 1, valid bit of the last stage.
- o_Data, out, DBITS, data payload of the last stage.
- o_Ctrl, out, CBITS, control payload of the last stage; forced to CTRL_RST whenever o_Valid is 0.
- o_StallCnt, out, CNT_W, number of stall cycles.
- o_FlushCnt, out, CNT_W, number of flush cycles.

## Operation
- Internal state per stage k (0..STAGES-1): valid_k, data_k, ctrl_k. Stage 0 is fed from the inputs; stage k is fed from stage k-1.
- Priority per rising edge, highest first:
  1. i_reset asserted: all valid_k = 0, data_k = 0, ctrl_k = CTRL_RST, counters = 0.
  2. i_Enable = 0: all state held. Flush, stall and counters are ignored.
  3. i_Flush = 1: all valid_k = 0 and ctrl_k = CTRL_RST. data_k is zeroed if CLEAR_DATA = 1, otherwise held. This applies even when i_Stall = 1; flush wins over stall.
  4. i_Stall = 1: all stages held.
  5. Otherwise: shift. Stage 0 takes {i_Valid, i_Data, i_Ctrl}; each later stage takes the previous stage.
- Loading a stage with valid = 0 (from i_Valid = 0 or from an upstream bubble) also forces its ctrl to CTRL_RST. A bubble therefore never carries RegWrite or MemWrite.
- Outputs are driven directly from the last stage's registers; there is no combinational path from input to output.
- Reset is asynchronous: asserting i_reset in the middle of a stall, or in the middle of a multi-stage fill, clears all state immediately without waiting for an edge. Release takes effect at the next edge.
- Illegal STAGES (0 or >4) is a fatal elaboration error via a generate-time check.

## Timing
- Latency: STAGES enabled, non-stalled cycles from i_Data to o_Data. With STAGES = 1, data presented before edge n appears on the outputs right after edge n.
- Throughput: one payload per enabled, non-stalled cycle.
- Stall of N cycles delays every in-flight payload by exactly N cycles. No payload is lost or duplicated.
- Flush affects state at the edge where it is sampled. The inputs presented in that cycle are discarded.
- Reset values of outputs:
  - o_Valid = 0
  - o_Data = 0
  - o_Ctrl = CTRL_RST
  - o_StallCnt = 0
  - o_FlushCnt = 0

## Configuration
- Macro PIPE_STATS_EN.
- Defined:
  - o_StallCnt increments on each edge with i_Enable = 1, i_Stall = 1 and i_Flush = 0.
  - o_FlushCnt increments on each edge with i_Enable = 1 and i_Flush = 1.
  - Both counters saturate at all-ones; they do not wrap.
  - i_CntClear zeroes both counters; it takes precedence over an increment in the same cycle.
- Undefined: the counter logic is not compiled in; o_StallCnt and o_FlushCnt are tied to 0, and i_CntClear is ignored.

## Test plan
- Reset and fill:
  - Stimulus: STAGES = 2; assert i_reset mid-run; release; then drive i_Valid = 1 with i_Data = 0x11, 0x22, 0x33 on consecutive cycles.
  - Required response: while reset is high, outputs are 0 / CTRL_RST; after release, o_Data shows 0x11, 0x22, 0x33 on the 2nd, 3rd and 4th edges.
- Stall hold:
  - Stimulus: STAGES = 1, i_Data = 0xA5; i_Stall high for 3 cycles while i_Data changes to 0x5A.
  - Required response: o_Data stays 0xA5 for 3 cycles, then becomes 0x5A; o_StallCnt = 3 with PIPE_STATS_EN defined.
- Flush over stall:
  - Stimulus: i_Ctrl = 0xFFFF, i_Valid = 1, then i_Flush = 1 and i_Stall = 1 in the same cycle; CLEAR_DATA = 0.
  - Required response: o_Valid = 0, o_Ctrl = CTRL_RST, o_Data unchanged; o_FlushCnt = 1 and o_StallCnt unchanged.
- Bubble control gating:
  - Stimulus: i_Valid = 0, i_Ctrl = 0x00FF.
  - Required response: after latency, o_Valid = 0 and o_Ctrl = CTRL_RST.
- Debug freeze:
  - Stimulus: i_Enable = 0 for 4 cycles while pulsing i_Flush and i_Stall.
  - Required response: all outputs and counters unchanged; normal shifting resumes on the first edge with i_Enable = 1.
- Counter saturation and clear:
  - Stimulus: CNT_W = 4, hold i_Stall for 20 cycles, then pulse i_CntClear together with i_Stall.
  - Required response: o_StallCnt stops at 15, then reads 0 after the clear edge.
